imem_loadable: RTL and testbench



---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_sp_ram.sv | 51 +++++
 rtl/imem_loadable.sv | 215 +++++++++++++++++++++
 tb/tb_imem_loadable.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the loadable instruction
//                memory: controller state encoding, fetch alignment and the
//                filler word returned for faulting fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Controller states. CLEAR zeroes the array after reset, RUN serves
    // fetches, LOAD streams a new program in from word 0.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Fetch addresses are byte addresses of 4-byte words.
    localparam int ALIGN_BITS = 2;

    // Word returned on a faulting fetch (all zeros executes as a NOP).
    // Kept wide so any DATA_W can take its low bits with a size cast.
    localparam logic [1023:0] NOP_WORD = '0;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_sp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_sp_ram
//  Description : Single-port RAM, DATA_W x DEPTH, synchronous write and
//                synchronous registered read. The array itself has no reset;
//                only the read-data register is reset so the fetch port
//                presents zero out of reset.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                i_we, i_wdata    - write strobe and data
//                i_re             - read strobe; o_rdata holds when low
//                i_addr           - word address (caller keeps it < DEPTH)
//                o_rdata          - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_sp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read data only moves on a read strobe, so the last fetched word stays
    // on the output while the array is being written or left idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : imem_sp_ram
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loadable
//  Description : Clocked, run-time loadable instruction memory. After reset
//                the array is zeroed one word per cycle (CLEAR), then fetches
//                are served with one-cycle latency (RUN). The host may reload
//                any prefix of the array through a streaming port (LOAD).
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                i_fetch_req / i_fetch_addr - fetch request, byte address
//                o_fetch_ready              - fetch accepted when high w/ req
//                o_instr_valid/_data/_fault - fetch response, one cycle later
//                i_load_start               - begin a load at word 0 (RUN)
//                i_load_valid/_data/_last   - streamed program words
//                o_load_ready               - load word accepted w/ valid
//                o_load_count               - words written by last load
//                o_busy                     - high whenever not in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loadable
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_ready,
    output logic              o_instr_valid,
    output logic [DATA_W-1:0] o_instr_data,
    output logic              o_instr_fault,
    // load port
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic [CNT_W-1:0]  o_load_count,
    output logic              o_busy
);

    localparam int                AW          = $clog2(DEPTH);
    localparam int                IDX_W       = ADDR_W - ALIGN_BITS;
    localparam logic [CNT_W-1:0]  C_LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]  C_DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [DATA_W-1:0] C_NOP       = DATA_W'(NOP_WORD);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;          // clear / load word pointer
    logic [CNT_W-1:0]   r_load_count;
    logic               r_fetch_en;     // registered "state == RUN"
    logic               r_load_ready;   // registered "state == LOAD"
    logic               r_busy;
    logic               r_instr_valid;
    logic               r_instr_fault;

    // ------------------------------------------------------------------
    // Fetch decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_index;
    logic               w_aligned;
    logic               w_in_range;
    logic               w_fetch_ok;
    logic               w_fetch_ready;
    logic               w_fetch_accept;
    logic               w_cnt_at_end;

    assign w_index        = i_fetch_addr[ADDR_W-1:ALIGN_BITS];
    assign w_aligned      = (i_fetch_addr[ALIGN_BITS-1:0] == '0);
    assign w_in_range     = (w_index < C_DEPTH_IDX);
    assign w_fetch_ok     = w_aligned && w_in_range;
    // A same-cycle load_start wins over the fetch, so it is refused here.
    assign w_fetch_ready  = r_fetch_en && !i_load_start;
    assign w_fetch_accept = w_fetch_ready && i_fetch_req;
    assign w_cnt_at_end   = (r_cnt == C_LAST_CNT);

    // ------------------------------------------------------------------
    // RAM port steering: each state owns the single port exclusively, so
    // a read and a write can never coincide.
    // ------------------------------------------------------------------
    logic               w_ram_we;
    logic               w_ram_re;
    logic [AW-1:0]      w_ram_addr;
    logic [DATA_W-1:0]  w_ram_wdata;
    logic [DATA_W-1:0]  w_ram_rdata;

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = r_cnt[AW-1:0];
        w_ram_wdata = C_NOP;
        case (r_state)
            CLEAR: begin
                w_ram_we = 1'b1;
            end
            LOAD: begin
                w_ram_we    = i_load_valid;
                w_ram_wdata = i_load_data;
            end
            RUN: begin
                // Faulting fetches never touch the array; their response is
                // forced to the NOP word at the output instead.
                w_ram_re   = w_fetch_accept && w_fetch_ok;
                w_ram_addr = w_index[AW-1:0];
            end
            default: begin
                w_ram_we = 1'b0;
            end
        endcase
    end

    imem_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CLEAR;
            r_cnt         <= '0;
            r_load_count  <= '0;
            r_fetch_en    <= 1'b0;
            r_load_ready  <= 1'b0;
            r_busy        <= 1'b1;
            r_instr_valid <= 1'b0;
            r_instr_fault <= 1'b0;
        end else begin
            // Response flags follow the previous cycle's acceptance; the
            // fault flag holds alongside the read register when idle.
            r_instr_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_instr_fault <= !w_fetch_ok;
            end

            case (r_state)
                CLEAR: begin
                    if (w_cnt_at_end) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        r_fetch_en <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                RUN: begin
                    if (i_load_start) begin
                        r_state      <= LOAD;
                        r_cnt        <= '0;
                        r_load_count <= '0;
                        r_fetch_en   <= 1'b0;
                        r_load_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_load_valid) begin
                        r_load_count <= r_cnt + C_CNT_ONE;
                        // Ending on the last array word protects against a
                        // host that streams more words than the memory holds.
                        if (i_load_last || w_cnt_at_end) begin
                            r_state      <= RUN;
                            r_cnt        <= '0;
                            r_fetch_en   <= 1'b1;
                            r_load_ready <= 1'b0;
                            r_busy       <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state      <= CLEAR;
                    r_cnt        <= '0;
                    r_fetch_en   <= 1'b0;
                    r_load_ready <= 1'b0;
                    r_busy       <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_fetch_ready = w_fetch_ready;
    assign o_instr_valid = r_instr_valid;
    assign o_instr_data  = r_instr_fault ? C_NOP : w_ram_rdata;
    assign o_instr_fault = r_instr_fault;
    assign o_load_ready  = r_load_ready;
    assign o_load_count  = r_load_count;
    assign o_busy        = r_busy;

endmodule : imem_loadable
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loadable
//  Description : Self-checking bench for imem_loadable (DEPTH=32). Keeps a
//                word-array reference of the program memory and predicts
//                every fetch response from the address rules directly.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loadable;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic              instr_fault;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [CNT_W-1:0]  load_count;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] ld_words [$];
    int                model_cnt;
    bit                model_active;

    always #5 clk = ~clk;

    imem_loadable #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_fetch_req   (fetch_req),
        .i_fetch_addr  (fetch_addr),
        .o_fetch_ready (fetch_ready),
        .o_instr_valid (instr_valid),
        .o_instr_data  (instr_data),
        .o_instr_fault (instr_fault),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .o_load_count  (load_count),
        .o_busy        (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic model_fault(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
        logic [IW-1:0] idx;
        if (model_fault(a)) return '0;
        idx = a[IW+1:2];
        return ref_mem[idx];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
    endtask

    // Streams ld_words[0..n-1]; load_last on index last_at (-1: never).
    // If the model says the load is still open afterwards, one random word
    // with load_last closes it so every call ends back in RUN.
    task automatic do_load(input int n, input int last_at);
        logic [DATA_W-1:0] extra;
        load_start = 1'b1;
        step();
        load_start   = 1'b0;
        model_active = 1'b1;
        model_cnt    = 0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = ld_words[i];
            load_last  = (i == last_at);
            step();
            if (model_active) begin
                ref_mem[IW'(model_cnt)] = ld_words[i];
                model_cnt++;
                if (i == last_at || model_cnt == DEPTH) model_active = 1'b0;
            end
        end
        if (model_active) begin
            extra      = $urandom;
            load_valid = 1'b1;
            load_data  = extra;
            load_last  = 1'b1;
            step();
            ref_mem[IW'(model_cnt)] = extra;
            model_cnt++;
            model_active = 1'b0;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({fetch_ready, instr_valid, instr_fault, load_ready, busy} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: got fr/iv/if/lr/busy=%b expected 00001",
                     {fetch_ready, instr_valid, instr_fault, load_ready, busy});
        end
        checks++;
        if (instr_data !== '0 || load_count !== '0) begin
            errors++;
            $display("FAIL reset_values: got data=%h count=%0d expected 0/0", instr_data, load_count);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst_n = 1'b1;
        // CLEAR must hold off fetches for exactly DEPTH cycles
        for (int k = 0; k < DEPTH; k++) begin
            if (fetch_ready !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_hold: %0d cycles with fetch_ready/busy wrong, expected 0", bad);
        end
        checks++;
        if (fetch_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: got fetch_ready=%b busy=%b expected 1/0", fetch_ready, busy);
        end
    endtask

    task automatic test_fetch_after_clear();
        do_fetch(32'h0);
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h0 || instr_fault !== 1'b0) begin
            errors++;
            $display("FAIL fetch_zero: got v=%b d=%h f=%b expected 1/00000000/0",
                     instr_valid, instr_data, instr_fault);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: got instr_valid=%b expected 0", instr_valid);
        end
    endtask

    task automatic test_load_basic();
        ld_words = '{32'h00430800, 32'h00822801, 32'h08250014};
        do_load(3, 2);
        checks++;
        if (load_count !== CNT_W'(3) || busy !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_basic: got count=%0d busy=%b lr=%b expected 3/0/0",
                     load_count, busy, load_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] held;
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h08250014 || instr_fault !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got v=%b d=%h f=%b expected 1/08250014/0",
                     instr_valid, instr_data, instr_fault);
        end
        fetch_addr = 32'h4;
        step();
        fetch_req = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h00822801 || instr_fault !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got v=%b d=%h f=%b expected 1/00822801/0",
                     instr_valid, instr_data, instr_fault);
        end
        held = model_data(32'h4);
        step();
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== held) begin
            errors++;
            $display("FAIL b2b_hold: got v=%b d=%h expected 0/%h", instr_valid, instr_data, held);
        end
    endtask

    task automatic test_fault();
        do_fetch(32'h6);
        checks++;
        if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instr_data !== '0) begin
            errors++;
            $display("FAIL fault_misalign: got v=%b f=%b d=%h expected 1/1/00000000",
                     instr_valid, instr_fault, instr_data);
        end
        do_fetch(32'h80);
        checks++;
        if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instr_data !== '0) begin
            errors++;
            $display("FAIL fault_range: got v=%b f=%b d=%h expected 1/1/00000000",
                     instr_valid, instr_fault, instr_data);
        end
        do_fetch(32'h7C);
        checks++;
        if (instr_fault !== 1'b0 || instr_data !== model_data(32'h7C)) begin
            errors++;
            $display("FAIL last_word_ok: got f=%b d=%h expected 0/%h",
                     instr_fault, instr_data, model_data(32'h7C));
        end
    endtask

    task automatic test_overflow_load();
        int bad = 0;
        logic [DATA_W-1:0] w31;
        logic [DATA_W-1:0] w0;
        ld_words.delete();
        for (int i = 0; i < 40; i++) ld_words.push_back($urandom | 32'h1);
        load_start = 1'b1;
        step();
        load_start   = 1'b0;
        model_active = 1'b1;
        model_cnt    = 0;
        for (int i = 0; i < 40; i++) begin
            if (load_ready !== model_active) bad++;
            load_valid = 1'b1;
            load_data  = ld_words[i];
            step();
            if (model_active) begin
                ref_mem[IW'(model_cnt)] = ld_words[i];
                model_cnt++;
                if (model_cnt == DEPTH) model_active = 1'b0;
            end
        end
        load_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL overflow_ready: %0d cycles with wrong load_ready, expected 0", bad);
        end
        checks++;
        if (load_count !== CNT_W'(DEPTH) || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_count: got count=%0d busy=%b expected %0d/0", load_count, busy, DEPTH);
        end
        w31 = ld_words[31];
        w0  = ld_words[0];
        do_fetch(32'h7C);
        checks++;
        if (instr_data !== w31 || instr_fault !== 1'b0) begin
            errors++;
            $display("FAIL overflow_word31: got d=%h f=%b expected %h/0", instr_data, instr_fault, w31);
        end
        do_fetch(32'h0);
        checks++;
        if (instr_data !== w0) begin
            errors++;
            $display("FAIL overflow_word0: got d=%h expected %h", instr_data, w0);
        end
    endtask

    task automatic test_load_start_priority();
        logic [DATA_W-1:0] wa;
        logic [DATA_W-1:0] wb;
        wa = $urandom;
        wb = $urandom;
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready: got fetch_ready=%b expected 0", fetch_ready);
        end
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_state: got v=%b busy=%b lr=%b expected 0/1/1", instr_valid, busy, load_ready);
        end
        // load_start while already loading must not restart the pointer
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = wa;
        step();
        load_start = 1'b0;
        load_data  = wb;
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        ref_mem[0] = wa;
        ref_mem[1] = wb;
        checks++;
        if (load_count !== CNT_W'(2) || busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_count: got count=%0d busy=%b expected 2/0", load_count, busy);
        end
        do_fetch(32'h4);
        checks++;
        if (instr_data !== wb) begin
            errors++;
            $display("FAIL prio_word1: got %h expected %h", instr_data, wb);
        end
    endtask

    task automatic test_random();
        logic              exp_valid = 1'b0;
        logic [DATA_W-1:0] exp_data  = '0;
        logic              exp_fault = 1'b0;
        logic [ADDR_W-1:0] a;
        logic              req;
        int                bad;
        int                n;
        int                last_at;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, DEPTH + 4);
            last_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            ld_words.delete();
            for (int i = 0; i < n; i++) ld_words.push_back($urandom);
            do_load(n, last_at);
            checks++;
            if (load_count !== CNT_W'(model_cnt) || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_load%0d: got count=%0d busy=%b expected %0d/0",
                         r, load_count, busy, model_cnt);
            end
            bad = 0;
            exp_valid = 1'b0;
            exp_data  = instr_data;
            exp_fault = instr_fault;
            for (int c = 0; c < 80; c++) begin
                req = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) != 0) a = ADDR_W'($urandom_range(0, DEPTH - 1)) << 2;
                else                           a = ADDR_W'($urandom_range(0, 4 * DEPTH + 8));
                fetch_req  = req;
                fetch_addr = a;
                step();
                if (req) begin
                    exp_valid = 1'b1;
                    exp_data  = model_data(a);
                    exp_fault = model_fault(a);
                end else begin
                    exp_valid = 1'b0;
                end
                if (instr_valid !== exp_valid || instr_data !== exp_data || instr_fault !== exp_fault) begin
                    bad++;
                    if (bad <= 3)
                        $display("FAIL rand_fetch r%0d c%0d: got v=%b d=%h f=%b expected %b/%h/%b",
                                 r, c, instr_valid, instr_data, instr_fault, exp_valid, exp_data, exp_fault);
                end
            end
            fetch_req = 1'b0;
            checks++;
            if (bad != 0) errors++;
        end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom | 32'h1;
            step();
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fetch_ready, instr_valid, instr_fault, load_ready, busy} !== 5'b00001 ||
            instr_data !== '0 || load_count !== '0) begin
            errors++;
            $display("FAIL midload_reset: got fr/iv/if/lr/busy=%b d=%h cnt=%0d expected 00001/0/0",
                     {fetch_ready, instr_valid, instr_fault, load_ready, busy}, instr_data, load_count);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        step();
        rst_n = 1'b1;
        wait_run(DEPTH + 5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midload_clear_timeout: got busy=%b expected 0", busy);
        end
        do_fetch(32'h0);
        checks++;
        if (instr_data !== '0 || instr_fault !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL midload_word0: got v=%b d=%h f=%b expected 1/00000000/0",
                     instr_valid, instr_data, instr_fault);
        end
        do_fetch(32'h10);
        checks++;
        if (instr_data !== model_data(32'h10)) begin
            errors++;
            $display("FAIL midload_word4: got %h expected %h", instr_data, model_data(32'h10));
        end
    endtask

    initial begin
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        test_reset();
        test_fetch_after_clear();
        test_load_basic();
        test_back_to_back();
        test_fault();
        test_overflow_load();
        test_load_start_priority();
        test_random();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_imem_loadable
`default_nettype wire
